// File: rtl/inst_fetch_buffer.sv
// Decode-side instruction fetch buffer: credit-controlled fetch requests, a small FIFO that
// absorbs bus latency, a bypass path into the decode register, and flush with in-flight drop.
module inst_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic          fetch_req,
  input  logic          fetch_gnt,
  input  logic          inst_rdata_ok,
  input  logic [31:0]   inst_rdata,
  input  logic [31:0]   inst_pc,
  input  logic          stallD,
  input  logic          flushD,
  output logic [31:0]   instrD,
  output logic [31:0]   pcD,
  output logic          instr_validD,
  output logic [AW:0]   count
);

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   inflight;
  logic [AW:0]   drop;
  logic [AW:0]   inflight_nxt;
  logic [AW+1:0] credit_used;
  logic          grant;
  logic          rsp_drop;
  logic          live;
  logic          empty;
  logic          pop;
  logic          bypass;
  logic          push;

  // Credit covers both buffered words and requests whose responses are still on the bus,
  // so a live response always finds a free FIFO slot even while decode is stalled.
  always_comb begin
    credit_used  = {1'b0, count} + {1'b0, inflight};
    fetch_req    = !rst && !flushD && (credit_used < (AW+2)'(DEPTH));
    grant        = fetch_req && fetch_gnt;
    rsp_drop     = inst_rdata_ok && (drop != '0);
    live         = inst_rdata_ok && (drop == '0) && !flushD;
    empty        = (count == '0);
    pop          = !flushD && !stallD && !empty;
    bypass       = !flushD && !stallD && empty && live;
    push         = live && !bypass;
    inflight_nxt = inflight + {{AW{1'b0}}, grant} - {{AW{1'b0}}, inst_rdata_ok};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= inst_rdata;
      mem_pc[wr_ptr]    <= inst_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      inflight     <= '0;
      drop         <= '0;
      instrD       <= '0;
      pcD          <= '0;
      instr_validD <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      if (flushD) begin
        // Everything still on the bus, including a grant this cycle, must be discarded.
        count        <= '0;
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        drop         <= inflight_nxt;
        instrD       <= '0;
        pcD          <= '0;
        instr_validD <= 1'b0;
      end else begin
        if (rsp_drop) drop <= drop - 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (!stallD) begin
          if (!empty) begin
            instrD       <= mem_instr[rd_ptr];
            pcD          <= mem_pc[rd_ptr];
            instr_validD <= 1'b1;
          end else if (live) begin
            instrD       <= inst_rdata;
            pcD          <= inst_pc;
            instr_validD <= 1'b1;
          end else begin
            instrD       <= '0;
            pcD          <= '0;
            instr_validD <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomised bench for inst_fetch_buffer: an in-order fetch-bus model with variable latency,
// a queue-based reference of the decode stream, and a scoreboard checked by a separate monitor.
module tb_inst_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req;
  logic        fetch_gnt = 1'b0;
  logic        inst_rdata_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic [31:0] inst_pc = '0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        instr_validD;
  logic [AW:0] count;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_gnt(fetch_gnt),
    .inst_rdata_ok(inst_rdata_ok), .inst_rdata(inst_rdata), .inst_pc(inst_pc),
    .stallD(stallD), .flushD(flushD), .instrD(instrD), .pcD(pcD),
    .instr_validD(instr_validD), .count(count)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
  } dreg_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          ready;
  } bus_t;

  dreg_t       sbq[$];
  dreg_t       pend[$];
  bus_t        busq[$];
  dreg_t       cur;
  dreg_t       mon_e;
  int          outst, to_drop, cyc;
  int          checks, errors;
  logic [31:0] next_pc;
  int          p_gnt, p_rsp, p_stall, p_flush, max_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    logic  exp_req;
    int    grant, rsp;
    bus_t  b;
    flushD    = ($urandom_range(99) < p_flush);
    stallD    = ($urandom_range(99) < p_stall);
    fetch_gnt = ($urandom_range(99) < p_gnt);
    rsp = 0;
    if (busq.size() > 0 && busq[0].ready <= cyc && $urandom_range(99) < p_rsp) begin
      rsp = 1;
      b = busq.pop_front();
      inst_rdata = b.instr;
      inst_pc    = b.pc;
    end else begin
      inst_rdata = $urandom;
      inst_pc    = $urandom;
    end
    inst_rdata_ok = (rsp != 0);
    #1;
    exp_req = !flushD && (pend.size() + outst < DEPTH);
    chk("fetch_req", 64'(fetch_req), 64'(exp_req));
    chk("count", 64'(count), 64'(pend.size()));
    grant = (exp_req && fetch_gnt) ? 1 : 0;
    if (grant != 0) begin
      b.instr = (next_pc == 32'hBFC0_0000) ? 32'h2402_0001 : $urandom;
      b.pc    = next_pc;
      b.ready = cyc + $urandom_range(max_lat, 1);
      busq.push_back(b);
      next_pc += 32'd4;
    end
    outst = outst + grant - rsp;
    if (flushD) begin
      pend.delete();
      to_drop = outst;
      cur = '0;
    end else begin
      if (rsp != 0) begin
        if (to_drop > 0) to_drop--;
        else pend.push_back('{v: 1'b1, instr: inst_rdata, pc: inst_pc});
      end
      if (!stallD) begin
        if (pend.size() > 0) cur = pend.pop_front();
        else cur = '0;
      end
    end
    sbq.push_back(cur);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_knobs(input int g, input int r, input int s, input int f, input int l);
    p_gnt = g; p_rsp = r; p_stall = s; p_flush = f; max_lat = l;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_instrD"}, 64'(instrD), 64'd0);
    chk({tag, "_pcD"}, 64'(pcD), 64'd0);
    chk({tag, "_validD"}, 64'(instr_validD), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_fetch_req"}, 64'(fetch_req), 64'd0);
  endtask

  task automatic model_reset();
    pend.delete(); busq.delete(); sbq.delete();
    outst = 0; to_drop = 0; cur = '0;
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("validD", 64'(instr_validD), 64'(mon_e.v));
      chk("instrD", 64'(instrD), 64'(mon_e.instr));
      chk("pcD", 64'(pcD), 64'(mon_e.pc));
    end
  end

  initial begin
    int guard;
    checks = 0; errors = 0; cyc = 0;
    next_pc = 32'hBFC0_0000;
    model_reset();
    set_knobs(0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Back-to-back single-cycle responses through the bypass path.
    set_knobs(100, 100, 0, 0, 1);
    repeat (8) step();

    // Long stall fills the FIFO up to the credit limit, then drains in order.
    set_knobs(100, 100, 100, 0, 1);
    repeat (6) step();
    set_knobs(100, 100, 0, 0, 1);
    repeat (8) step();

    // Flush with requests outstanding on a slow bus.
    set_knobs(100, 100, 0, 0, 3);
    repeat (2) step();
    set_knobs(100, 100, 0, 100, 3);
    step();
    set_knobs(100, 100, 0, 0, 3);
    repeat (10) step();

    set_knobs(70, 60, 30, 5, 4);
    repeat (600) step();

    // Asynchronous reset in the middle of a stalled burst.
    set_knobs(100, 100, 100, 0, 1);
    guard = 0;
    while (pend.size() != 3 && guard < 20) begin
      step();
      guard++;
    end
    chk("burst_fill", 64'(count), 64'd3);
    fetch_gnt = 1'b0; inst_rdata_ok = 1'b0; stallD = 1'b0; flushD = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    set_knobs(80, 70, 25, 4, 3);
    repeat (300) step();
    set_knobs(0, 100, 0, 0, 1);
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
